// File: rtl/regpair_loader.sv
// regpair_loader: assembles MSB-first byte records into BRAM writes, then hands off to camera_registers.
// Optional macro REGPAIR_CHECKSUM_EN adds a 4th XOR checksum byte to every record.
module regpair_loader #(
  parameter int unsigned RAM_DEPTH  = 256,
  parameter logic [23:0] TERMINATOR = 24'hFFFFFF
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         clear_in,
  input  logic [7:0]                   s_tdata,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  output logic [$clog2(RAM_DEPTH)-1:0] bram_addr,
  output logic [23:0]                  bram_din,
  output logic                         bram_we,
  output logic                         init_valid,
  input  logic                         init_ready,
  output logic [$clog2(RAM_DEPTH):0]   entry_count,
  output logic                         overflow,
  output logic [7:0]                   csum_err_count,
  output logic [2:0]                   state_out
);
  localparam int unsigned AW = $clog2(RAM_DEPTH);
  localparam int unsigned CW = AW + 1;
`ifdef REGPAIR_CHECKSUM_EN
  localparam int unsigned NB = 4;
`else
  localparam int unsigned NB = 3;
`endif
  localparam int unsigned SW = NB * 8;

  localparam logic [2:0] COLLECT = 3'd0;
  localparam logic [2:0] WRITE   = 3'd1;
  localparam logic [2:0] HANDOFF = 3'd2;
  localparam logic [2:0] DONE    = 3'd3;

  logic [2:0]    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [SW-1:0] asm_q, asm_d, asm_shift;
  logic [CW-1:0] cnt_d;
  logic          ovf_d, we_d;
  logic [AW-1:0] addr_d;
  logic [23:0]   din_d, rec_shift, rec_held;
  logic          hs, full, last_byte, shift_ok;

  assign hs        = s_tvalid && s_tready;
  assign full      = (entry_count == CW'(RAM_DEPTH));
  assign last_byte = (idx_q == 2'(NB - 1));
  assign asm_shift = {asm_q[SW-9:0], s_tdata};
  assign rec_shift = asm_shift[SW-1 -: 24];
  assign rec_held  = asm_q[SW-1 -: 24];
  assign state_out = state_q;

`ifdef REGPAIR_CHECKSUM_EN
  logic       held_ok;
  logic [7:0] err_d;
  assign shift_ok = ((asm_shift[31:24] ^ asm_shift[23:16] ^ asm_shift[15:8]) == asm_shift[7:0]);
  assign held_ok  = ((asm_q[31:24] ^ asm_q[23:16] ^ asm_q[15:8]) == asm_q[7:0]);
`else
  assign shift_ok       = 1'b1;
  assign csum_err_count = 8'd0;
`endif

  // Next state; write strobe is decided on the last byte so it lands registered in WRITE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    cnt_d   = entry_count;
    ovf_d   = overflow;
    we_d    = 1'b0;
    addr_d  = bram_addr;
    din_d   = bram_din;
`ifdef REGPAIR_CHECKSUM_EN
    err_d   = csum_err_count;
`endif
    case (state_q)
      COLLECT: begin
        if (hs) begin
          asm_d = asm_shift;
          if (last_byte) begin
            idx_d   = 2'd0;
            state_d = WRITE;
            we_d    = shift_ok && (rec_shift != TERMINATOR) && !full;
            if (we_d) begin
              addr_d = entry_count[AW-1:0];
              din_d  = rec_shift;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      WRITE: begin
        state_d = COLLECT;
`ifdef REGPAIR_CHECKSUM_EN
        if (!held_ok) begin
          if (csum_err_count != 8'hFF) err_d = csum_err_count + 8'd1;
        end else
`endif
        if (rec_held == TERMINATOR) state_d = HANDOFF;
        else if (full)              ovf_d   = 1'b1;
        else                        cnt_d   = entry_count + CW'(1);
      end
      HANDOFF: if (init_valid && init_ready) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = COLLECT;
    endcase
    if (clear_in) begin
      state_d = COLLECT;
      idx_d   = 2'd0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      we_d    = 1'b0;
`ifdef REGPAIR_CHECKSUM_EN
      err_d   = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= COLLECT;
      idx_q       <= 2'd0;
      asm_q       <= '0;
      entry_count <= '0;
      overflow    <= 1'b0;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_din    <= 24'd0;
      s_tready    <= 1'b1;
      init_valid  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      entry_count <= cnt_d;
      overflow    <= ovf_d;
      bram_we     <= we_d;
      bram_addr   <= addr_d;
      bram_din    <= din_d;
      s_tready    <= (state_d == COLLECT);
      init_valid  <= (state_d == HANDOFF);
    end
  end

`ifdef REGPAIR_CHECKSUM_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) csum_err_count <= 8'd0;
    else        csum_err_count <= err_d;
  end
`endif

endmodule

// File: tb/tb_regpair_loader.sv
// tb_regpair_loader: directed stimulus with a write scoreboard for regpair_loader (RAM_DEPTH=4).
module tb_regpair_loader;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          clear_in = 1'b0;
  logic [7:0]    s_tdata = 8'd0;
  logic          s_tvalid = 1'b0;
  logic          init_ready = 1'b0;
  logic          s_tready, bram_we, init_valid, overflow;
  logic [AW-1:0] bram_addr;
  logic [23:0]   bram_din;
  logic [AW:0]   entry_count;
  logic [7:0]    csum_err_count;
  logic [2:0]    state_out;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb[$];
  int          exp_count = 0;
  logic        exp_ovf = 1'b0;
  logic        prev_we = 1'b0;

  always #5 clk_in = ~clk_in;

  regpair_loader #(.RAM_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .clear_in(clear_in),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
    .init_valid(init_valid), .init_ready(init_ready),
    .entry_count(entry_count), .overflow(overflow),
    .csum_err_count(csum_err_count), .state_out(state_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk_in);
    @(negedge clk_in);
    s_tvalid = 1'b1;
    s_tdata  = b;
    while (s_tready !== 1'b1 && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    check("tready_wait", 32'(s_tready), 32'd1);
    @(posedge clk_in);
    #1;
    s_tvalid = 1'b0;
  endtask

  // Sends one record and predicts whether the WRITE cycle strobes the BRAM
  task automatic send_rec(input logic [23:0] rec, input int gap);
    logic exp_we = 1'b0;
    send_byte(rec[23:16], gap);
    send_byte(rec[15:8], gap);
    send_byte(rec[7:0], gap);
`ifdef REGPAIR_CHECKSUM_EN
    send_byte(rec[23:16] ^ rec[15:8] ^ rec[7:0], gap);
`endif
    if (rec != 24'hFFFFFF) begin
      if (exp_count < DEPTH) begin
        sb.push_back(32'({AW'(exp_count), rec}));
        exp_count++;
        exp_we = 1'b1;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    @(negedge clk_in);
    check("write_state", 32'(state_out), 32'd1);
    check("write_we", 32'(bram_we), 32'(exp_we));
    check("write_tready", 32'(s_tready), 32'd0);
    check("write_no_iv", 32'(init_valid), 32'd0);
  endtask

  task automatic do_clear();
    @(negedge clk_in);
    clear_in = 1'b1;
    @(negedge clk_in);
    clear_in = 1'b0;
    exp_count = 0;
    exp_ovf   = 1'b0;
    check("clr_state", 32'(state_out), 32'd0);
    check("clr_count", 32'(entry_count), 32'd0);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_tready", 32'(s_tready), 32'd1);
  endtask

  // Entered on a negedge with init_valid already expected high
  task automatic handoff(input int hold);
    repeat (hold) begin
      check("iv_hold", 32'(init_valid), 32'd1);
      @(negedge clk_in);
    end
    init_ready = 1'b1;
    @(negedge clk_in);
    init_ready = 1'b0;
    check("done_state", 32'(state_out), 32'd3);
    check("iv_drop", 32'(init_valid), 32'd0);
    check("done_tready", 32'(s_tready), 32'd0);
  endtask

  always @(negedge clk_in) begin : monitor
    logic [31:0] exp_w;
    if (bram_we === 1'b1) begin
      exp_w = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      check("bram_write", 32'({bram_addr, bram_din}), exp_w);
      if (prev_we) check("we_pulse", 32'(bram_we), 32'd0);
    end
    prev_we <= bram_we;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1;
    @(negedge clk_in);
    check("rst_tready", 32'(s_tready), 32'd1);
    check("rst_we", 32'(bram_we), 32'd0);
    check("rst_addr", 32'(bram_addr), 32'd0);
    check("rst_din", 32'(bram_din), 32'd0);
    check("rst_iv", 32'(init_valid), 32'd0);
    check("rst_count", 32'(entry_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_csum", 32'(csum_err_count), 32'd0);
    check("rst_state", 32'(state_out), 32'd0);
    rst_in = 1'b0;

    // Basic two-record table
    send_rec(24'h301C80, 0);
    send_rec(24'h310811, 0);
    send_rec(24'hFFFFFF, 0);
    @(negedge clk_in);
    check("iv_rise", 32'(init_valid), 32'd1);
    check("handoff_state", 32'(state_out), 32'd2);
    check("handoff_tready", 32'(s_tready), 32'd0);
    check("count_two", 32'(entry_count), 32'd2);
    handoff(3);
    check("done_count", 32'(entry_count), 32'd2);

    // Same table with valid gaps and a slow init_ready
    do_clear();
    send_rec(24'h301C80, 5);
    send_rec(24'h310811, 5);
    send_rec(24'hFFFFFF, 5);
    @(negedge clk_in);
    handoff(20);
    check("gap_count", 32'(entry_count), 32'd2);

    // Overflow at depth 4
    do_clear();
    for (int i = 0; i < 6; i++) begin
      send_rec(24'h400000 + 24'(i * 17), 0);
      if (i == 3) check("ovf_not_yet", 32'(overflow), 32'd0);
    end
    check("ovf_set", 32'(overflow), 32'(exp_ovf));
    check("count_full", 32'(entry_count), 32'(DEPTH));
    send_rec(24'hFFFFFF, 0);
    @(negedge clk_in);
    handoff(1);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Partial record discarded by clear
    do_clear();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    do_clear();
    send_rec(24'h123456, 0);
    send_rec(24'hFFFFFF, 0);
    @(negedge clk_in);
    check("partial_count", 32'(entry_count), 32'd1);
    handoff(1);

    // Empty table still hands off
    do_clear();
    send_rec(24'hFFFFFF, 0);
    @(negedge clk_in);
    check("empty_count", 32'(entry_count), 32'd0);
    handoff(1);

    // Asynchronous reset during HANDOFF
    do_clear();
    send_rec(24'h301C80, 0);
    send_rec(24'hFFFFFF, 0);
    @(negedge clk_in);
    check("pre_rst_iv", 32'(init_valid), 32'd1);
    #2;
    rst_in = 1'b1;
    #1;
    check("async_iv", 32'(init_valid), 32'd0);
    check("async_tready", 32'(s_tready), 32'd1);
    check("async_state", 32'(state_out), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    exp_count = 0;
    exp_ovf   = 1'b0;

`ifdef REGPAIR_CHECKSUM_EN
    send_rec(24'h300802, 0);
    send_byte(8'h30, 0);
    send_byte(8'h08, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    @(negedge clk_in);
    check("bad_csum_we", 32'(bram_we), 32'd0);
    @(negedge clk_in);
    check("csum_err", 32'(csum_err_count), 32'd1);
    check("csum_count", 32'(entry_count), 32'd1);
    check("csum_state", 32'(state_out), 32'd0);
`else
    send_rec(24'h300802, 0);
    @(negedge clk_in);
    check("csum_tied", 32'(csum_err_count), 32'd0);
    check("post_rst_count", 32'(entry_count), 32'd1);
`endif

    repeat (3) @(negedge clk_in);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
